// File: rtl/cmd_ts_arbiter_if.sv
// Requester and cmd_queue write-side signals of cmd_ts_arbiter.
// master is the arbiter's view; slave is the requesters/cmd_queue view.
interface cmd_ts_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int TS_BITS = 30
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*TS_BITS-1:0] req_data;
  logic [NREQ-1:0]         req_done;
  logic [NREQ-1:0]         req_late;
  logic                    newcmd_valid;
  logic                    newcmd_ready;
  logic [TS_BITS-1:0]      newcmd_data;

  modport master (
    input  req_valid, req_data, newcmd_ready,
    output req_ready, req_done, req_late, newcmd_valid, newcmd_data
  );

  modport slave (
    output req_valid, req_data, newcmd_ready,
    input  req_ready, req_done, req_late, newcmd_valid, newcmd_data
  );
endinterface

// File: rtl/cmd_ts_arbiter.sv
// Round-robin, credit-gated arbiter for the cmd_queue write port with owner tracking.
// Optional macro CMD_ARB_ORDER_CHECK_EN rejects timestamps older than the last issued one.
module cmd_ts_arbiter #(
  parameter int NREQ           = 4,
  parameter int TS_BITS        = 30,
  parameter int CMD_QUEUE_BITS = 5
) (
  input  logic                    newcmd_clk,
  input  logic                    newcmd_reset,
  cmd_ts_arbiter_if.master        bus,
  input  logic                    cmd_done,
  output logic [CMD_QUEUE_BITS:0] credits,
  output logic                    err_underflow
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CREDITS = 2 ** CMD_QUEUE_BITS;

  typedef enum logic {ST_ARB, ST_ISSUE} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          winner;
  logic [IDX_W-1:0]          win_idx;
  logic                      found;
  logic [TS_BITS-1:0]        win_ts;
  logic                      win_late;
  logic                      grant;
  logic                      reject;
  logic                      issue;
  logic                      pop;
  logic                      fifo_empty;
  logic [IDX_W-1:0]          tag_mem [CREDITS];
  logic [CMD_QUEUE_BITS-1:0] wr_ptr;
  logic [CMD_QUEUE_BITS-1:0] rd_ptr;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_ts = bus.req_data[win_idx*TS_BITS +: TS_BITS];

`ifdef CMD_ARB_ORDER_CHECK_EN
  logic [TS_BITS-1:0] last_issued_ts;
  logic               have_last;

  // Late means the modular distance from the last issued timestamp is negative.
  assign win_late = have_last && ($signed(TS_BITS'(win_ts - last_issued_ts)) < 0);

  always_ff @(posedge newcmd_clk or posedge newcmd_reset) begin
    if (newcmd_reset) begin
      last_issued_ts <= '0;
      have_last      <= 1'b0;
    end else if (issue) begin
      last_issued_ts <= bus.newcmd_data;
      have_last      <= 1'b1;
    end
  end
`else
  assign win_late = 1'b0;
`endif

  assign fifo_empty = (credits == (CMD_QUEUE_BITS+1)'(CREDITS));
  assign issue      = bus.newcmd_valid & bus.newcmd_ready;
  assign pop        = cmd_done & ~fifo_empty;
  assign reject     = (state == ST_ARB) & found & win_late;
  assign grant      = (state == ST_ARB) & found & ~win_late & (credits != '0);

  // Accept/reject must be seen in the handshake cycle itself, otherwise a
  // still-valid requester would be granted a second time on the next ARB cycle.
  assign bus.req_ready = issue  ? (NREQ'(1) << winner)  :
                         reject ? (NREQ'(1) << win_idx) : '0;
  assign bus.req_late  = reject ? (NREQ'(1) << win_idx) : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge newcmd_clk or posedge newcmd_reset) begin
    if (newcmd_reset) begin
      state            <= ST_ARB;
      rr_ptr           <= '0;
      winner           <= '0;
      bus.newcmd_valid <= 1'b0;
      bus.newcmd_data  <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (grant) begin
            winner           <= win_idx;
            bus.newcmd_data  <= win_ts;
            bus.newcmd_valid <= 1'b1;
            state            <= ST_ISSUE;
          end else if (reject) begin
            rr_ptr <= next_idx(win_idx);
          end
        end
        ST_ISSUE: begin
          if (bus.newcmd_ready) begin
            bus.newcmd_valid <= 1'b0;
            rr_ptr           <= next_idx(winner);
            state            <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  always_ff @(posedge newcmd_clk or posedge newcmd_reset) begin
    if (newcmd_reset) begin
      credits       <= (CMD_QUEUE_BITS+1)'(CREDITS);
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.req_done  <= '0;
      err_underflow <= 1'b0;
    end else begin
      bus.req_done <= pop ? (NREQ'(1) << tag_mem[rd_ptr]) : '0;
      if (issue) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (cmd_done && fifo_empty) err_underflow <= 1'b1;
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // NOTE: tag storage is not reset; the pointers and credits define which entries are valid.
  always_ff @(posedge newcmd_clk) begin
    if (issue) tag_mem[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_cmd_ts_arbiter.sv
// Scenario bench for cmd_ts_arbiter: expected issues and owners are queued as
// stimulus is driven and popped when the arbiter issues or completes a command.
module tb_cmd_ts_arbiter;
  localparam int NREQ    = 4;
  localparam int TS_BITS = 30;
  localparam int CQB     = 5;
  localparam int CREDITS = 32;

  typedef struct {
    int                 owner;
    logic [TS_BITS-1:0] ts;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_done;
  logic [CQB:0]       credits;
  logic               err_underflow;
  logic [TS_BITS-1:0] ts_of [NREQ];
  exp_t               exp_q [$];
  int                 owner_q [$];
  int                 n_cmp = 0;
  int                 n_bad = 0;

  cmd_ts_arbiter_if #(.NREQ(NREQ), .TS_BITS(TS_BITS)) bus ();

  cmd_ts_arbiter #(.NREQ(NREQ), .TS_BITS(TS_BITS), .CMD_QUEUE_BITS(CQB)) dut (
    .newcmd_clk    (clk),
    .newcmd_reset  (rst),
    .bus           (bus),
    .cmd_done      (cmd_done),
    .credits       (credits),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [NREQ-1:0] onehot(input int o);
    logic [NREQ-1:0] v;
    v    = '0;
    v[o] = 1'b1;
    return v;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*TS_BITS +: TS_BITS] = ts_of[i];
  endtask

  task automatic apply_reset();
    rst              = 1'b1;
    cmd_done         = 1'b0;
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.newcmd_ready = 1'b1;
    exp_q.delete();
    owner_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (from a negedge) for newcmd_valid; an expired budget counts as a failed comparison.
  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.newcmd_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: newcmd_valid not seen within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (credits !== 6'd32) begin n_bad++; $display("FAIL rst_credits: got %0d want 32", credits); end
    n_cmp++; if (bus.newcmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.newcmd_valid); end
    n_cmp++; if (bus.newcmd_data !== '0) begin n_bad++; $display("FAIL rst_data: got %0d want 0", bus.newcmd_data); end
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.req_done !== 4'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0000", bus.req_done); end
    n_cmp++; if (bus.req_late !== 4'b0) begin n_bad++; $display("FAIL rst_late: got %b want 0000", bus.req_late); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_underflow); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   issues;
    apply_reset();
    for (int i = 0; i < NREQ; i++) ts_of[i] = TS_BITS'(i + 1);
    drive_data();
    for (int k = 0; k < CREDITS; k++) begin
      e.owner = k % NREQ;
      e.ts    = TS_BITS'(k + 1);
      exp_q.push_back(e);
    end
    bus.req_valid = '1;
    @(negedge clk);
    n_cmp++; if (bus.newcmd_valid !== 1'b1) begin n_bad++; $display("FAIL rr_latency: newcmd_valid %b one cycle after req_valid, want 1", bus.newcmd_valid); end
    issues = 0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.newcmd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rr_extra_issue: newcmd_valid with data %0d after credit limit", bus.newcmd_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (bus.newcmd_data !== e.ts) begin n_bad++; $display("FAIL rr_data: issue %0d got %0d want %0d", issues, bus.newcmd_data, e.ts); end
          n_cmp++; if (bus.req_ready !== onehot(e.owner)) begin n_bad++; $display("FAIL rr_ready: issue %0d got %b want %b", issues, bus.req_ready, onehot(e.owner)); end
          owner_q.push_back(e.owner);
          ts_of[e.owner] = ts_of[e.owner] + TS_BITS'(NREQ);
          drive_data();
        end
        issues++;
      end
    end
    n_cmp++; if (issues !== CREDITS) begin n_bad++; $display("FAIL rr_count: got %0d issues want %0d", issues, CREDITS); end
    n_cmp++; if (credits !== 6'd0) begin n_bad++; $display("FAIL rr_credits: got %0d want 0", credits); end
  endtask

  task automatic test_credit_return();
    exp_t e;
    bit   seen;
    int   extra;
    bus.req_valid[0] = 1'b0;
    e.owner = 1;
    e.ts    = ts_of[1];
    exp_q.push_back(e);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    n_cmp++; if (bus.req_done !== onehot(owner_q.pop_front())) begin n_bad++; $display("FAIL cr_done: got %b want 0001", bus.req_done); end
    n_cmp++; if (credits !== 6'd1) begin n_bad++; $display("FAIL cr_credits: got %0d want 1", credits); end
    wait_valid(6, seen);
    if (seen) begin
      e = exp_q.pop_front();
      n_cmp++; if (bus.newcmd_data !== e.ts) begin n_bad++; $display("FAIL cr_data: got %0d want %0d", bus.newcmd_data, e.ts); end
      n_cmp++; if (bus.req_ready !== onehot(e.owner)) begin n_bad++; $display("FAIL cr_ready: got %b want %b", bus.req_ready, onehot(e.owner)); end
      owner_q.push_back(e.owner);
      ts_of[e.owner] = ts_of[e.owner] + TS_BITS'(NREQ);
      drive_data();
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.newcmd_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL cr_gate: got %0d valid cycles at zero credits want 0", extra); end
    n_cmp++; if (credits !== 6'd0) begin n_bad++; $display("FAIL cr_credits_after: got %0d want 0", credits); end
  endtask

  task automatic test_back_to_back_done();
    exp_t e;
    bit   seen;
    int   drain;
    e.owner = 2;
    e.ts    = ts_of[2];
    exp_q.push_back(e);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    n_cmp++; if (bus.req_done !== onehot(owner_q.pop_front())) begin n_bad++; $display("FAIL sc_done_first: got %b want 0010", bus.req_done); end
    wait_valid(6, seen);
    if (seen) begin
      e = exp_q.pop_front();
      n_cmp++; if (bus.newcmd_data !== e.ts) begin n_bad++; $display("FAIL sc_data: got %0d want %0d", bus.newcmd_data, e.ts); end
      owner_q.push_back(e.owner);
      bus.req_valid = '0;
      cmd_done      = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      n_cmp++; if (credits !== 6'd1) begin n_bad++; $display("FAIL sc_credits: got %0d want 1", credits); end
      n_cmp++; if (bus.req_done !== onehot(owner_q.pop_front())) begin n_bad++; $display("FAIL sc_done_head: got %b want 0100", bus.req_done); end
    end
    bus.req_valid = '0;
    drain = owner_q.size();
    for (int i = 0; i < drain; i++) begin
      cmd_done = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.req_done !== onehot(owner_q[0])) begin n_bad++; $display("FAIL drain_done: pop %0d got %b want %b", i, bus.req_done, onehot(owner_q[0])); end
      void'(owner_q.pop_front());
    end
    cmd_done = 1'b0;
    @(negedge clk);
    n_cmp++; if (credits !== 6'd32) begin n_bad++; $display("FAIL drain_credits: got %0d want 32", credits); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL drain_err: got %b want 0", err_underflow); end
  endtask

  task automatic test_underflow();
    apply_reset();
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_set: got %b want 1", err_underflow); end
    n_cmp++; if (bus.req_done !== 4'b0) begin n_bad++; $display("FAIL uf_done: got %b want 0000", bus.req_done); end
    repeat (3) @(negedge clk);
    n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
    n_cmp++; if (credits !== 6'd32) begin n_bad++; $display("FAIL uf_credits: got %0d want 32", credits); end
  endtask

`ifdef CMD_ARB_ORDER_CHECK_EN
  task automatic test_order_late();
    bit seen;
    int extra;
    apply_reset();
    bus.req_data[0 +: TS_BITS] = TS_BITS'(100);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    wait_valid(4, seen);
    if (seen) begin
      n_cmp++; if (bus.newcmd_data !== TS_BITS'(100)) begin n_bad++; $display("FAIL ol_first: got %0d want 100", bus.newcmd_data); end
    end
    bus.req_valid = '0;
    @(negedge clk);
    bus.req_data[TS_BITS +: TS_BITS] = TS_BITS'(50);
    bus.req_valid = 4'b0010;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL ol_ready: got %b want 0010", bus.req_ready); end
    n_cmp++; if (bus.req_late !== 4'b0010) begin n_bad++; $display("FAIL ol_late: got %b want 0010", bus.req_late); end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.newcmd_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ol_no_issue: got %0d valid cycles want 0", extra); end
    n_cmp++; if (credits !== 6'd31) begin n_bad++; $display("FAIL ol_credits: got %0d want 31", credits); end
  endtask

  task automatic test_order_wrap();
    bit seen;
    apply_reset();
    bus.req_data[0 +: TS_BITS] = TS_BITS'((1 << TS_BITS) - 10);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    wait_valid(4, seen);
    bus.req_valid = '0;
    @(negedge clk);
    bus.req_data[0 +: TS_BITS] = TS_BITS'(5);
    bus.req_valid = 4'b0001;
    #1;
    n_cmp++; if (bus.req_late !== 4'b0) begin n_bad++; $display("FAIL ow_late: got %b want 0000", bus.req_late); end
    @(negedge clk);
    wait_valid(4, seen);
    if (seen) begin
      n_cmp++; if (bus.newcmd_data !== TS_BITS'(5)) begin n_bad++; $display("FAIL ow_data: got %0d want 5", bus.newcmd_data); end
    end
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (credits !== 6'd30) begin n_bad++; $display("FAIL ow_credits: got %0d want 30", credits); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_credit_return();
    test_back_to_back_done();
    test_underflow();
`ifdef CMD_ARB_ORDER_CHECK_EN
    test_order_late();
    test_order_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
